secure_debug_readout: RTL and testbench
=======================================

SECURE_DEBUG_READOUT -- requirements
Module: secure_debug_readout

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each channel word and of the key.
REQ-002 SHALL have parameter NUM_CH, default 4, number of captured channels (range 1..16).
REQ-003 SHALL have parameter MAX_FAILS, default 3, wrong-key attempts before lockout.
REQ-004 SHALL have parameter LOCKOUT_CYC, default 1024, lockout duration in cycles.
REQ-005 SHALL have port clk, input, 1, sole clock; reset is synchronous and active-high.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port data_in, input, NUM_CH*DATA_W, functional channel data; channel i in bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port data_out, output, NUM_CH*DATA_W, captured channel registers.
REQ-009 SHALL have port prod_mode, input, 1, lifecycle production flag; high disables debug.
REQ-010 SHALL have port fuse_key, input, DATA_W, reference unlock key.
REQ-011 SHALL have port dbg_unlock_req, input, 1, single-cycle unlock attempt strobe.
REQ-012 SHALL have port dbg_key, input, DATA_W, key presented with dbg_unlock_req.
REQ-013 SHALL have port dbg_relock, input, 1, return to LOCKED.
REQ-014 SHALL have port dbg_rd_req, input, 1, read request strobe.
REQ-015 SHALL have port dbg_rd_ch, input, CH_W = max(1,$clog2(NUM_CH)), channel select.
REQ-016 SHALL have port dbg_rd_ack, output, 1, one-cycle read completion.
REQ-017 SHALL have port dbg_rd_data, output, DATA_W, read data, valid only with dbg_rd_ack.
REQ-018 SHALL have port dbg_rd_err, output, 1, read refused or bad channel, valid with dbg_rd_ack.
REQ-019 SHALL have ports dbg_unlocked and dbg_lockout, output, 1 each, state flags.

Function
REQ-020 SHALL register each channel of data_in into data_out every cycle (1-cycle latency), independent of debug state.
REQ-021 SHALL implement FSM LOCKED, CHECK, UNLOCKED, LOCKOUT.
REQ-022 In LOCKED, dbg_unlock_req SHALL latch dbg_key and go to CHECK.
REQ-023 CHECK (exactly 1 cycle) SHALL go to UNLOCKED and clear the fail counter on key match, else increment the fail counter.
REQ-024 On mismatch, fail counter reaching MAX_FAILS SHALL go to LOCKOUT and load the lockout counter with LOCKOUT_CYC-1; otherwise go to LOCKED.
REQ-025 LOCKOUT SHALL ignore all debug requests, decrement each cycle, and at zero go to LOCKED with fail counter cleared.
REQ-026 In UNLOCKED, dbg_relock SHALL go to LOCKED next cycle; dbg_relock outside UNLOCKED has no effect.
REQ-027 prod_mode high SHALL force LOCKED next cycle from any state, hold the fail counter, and ignore dbg_unlock_req.
REQ-028 Every dbg_rd_req SHALL produce dbg_rd_ack exactly one cycle later; at most one read in flight, back-to-back requests allowed.
REQ-029 Read in UNLOCKED with dbg_rd_ch < NUM_CH SHALL return data_out channel value as sampled at request cycle, dbg_rd_err=0.
REQ-030 Read in any other state, or with dbg_rd_ch >= NUM_CH, SHALL return dbg_rd_data=0, dbg_rd_err=1.
REQ-031 Simultaneous dbg_relock and dbg_rd_req in UNLOCKED SHALL serve the read (state at request cycle decides).
REQ-032 dbg_rd_data SHALL be 0 whenever dbg_rd_ack=0; key and fuse_key SHALL never reach any output.

Reset
REQ-033 rst SHALL set state LOCKED, both counters 0, data_out 0, dbg_rd_ack/dbg_rd_data/dbg_rd_err 0, dbg_unlocked 0, dbg_lockout 0.
REQ-034 rst mid-read or mid-lockout SHALL abort it; no ack issues after reset.

Structure
REQ-035 State enum and CH_W computation SHALL live in shared package dbg_sec_pkg.
REQ-036 Key compare/fail/lockout logic SHALL be sub-module dbg_auth_fsm; capture and read mux in top.

Verification
REQ-037 Reset, fuse_key=0xA5A5A5A5, unlock with 0xA5A5A5A5 -> dbg_unlocked=1 two cycles after strobe.
REQ-038 Unlocked, data_in ch2=0x12345678, read ch2 -> next cycle ack, data 0x12345678, err 0.
REQ-039 Three wrong keys -> dbg_lockout=1, correct key ignored for 1024 cycles, then accepted.
REQ-040 Locked read ch0 and unlocked read ch7 (NUM_CH=4) -> ack, data 0, err 1.
REQ-041 Unlocked, prod_mode=1 -> LOCKED next cycle; subsequent correct key -> dbg_unlocked stays 0.
REQ-042 rst asserted during LOCKOUT -> all outputs 0, LOCKED, unlock accepted after release.

Source files
------------

// File: rtl/dbg_sec_pkg.sv
// Shared types for the secure debug readout block: authentication FSM states
// and the channel-select width helper.
package dbg_sec_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } dbg_state_e;

    function automatic int calc_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/dbg_auth_fsm.sv
// Debug authentication: key compare, wrong-key counting and timed lockout.
//   state       | meaning
//   ST_LOCKED   | debug closed, waiting for an unlock attempt
//   ST_CHECK    | one cycle comparing the latched key with the fuse key
//   ST_UNLOCKED | debug reads allowed until relock or production mode
//   ST_LOCKOUT  | too many wrong keys, all requests ignored until timer expires
module dbg_auth_fsm
    import dbg_sec_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_mode,
    input  logic [DATA_W-1:0] fuse_key,
    input  logic              unlock_req,
    input  logic [DATA_W-1:0] key,
    input  logic              relock,
    output logic              unlocked,
    output logic              lockout
);

    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int LCK_W  = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);
    localparam logic [LCK_W-1:0]  LCK_LOAD = LCK_W'(LOCKOUT_CYC - 1);

    dbg_state_e        state_q;
    logic [FAIL_W-1:0] fail_q;
    logic [FAIL_W-1:0] fail_d;
    logic [LCK_W-1:0]  lck_q;
    logic [DATA_W-1:0] key_q;
    logic              unlocked_q;
    logic              lockout_q;

    // Saturate: production mode can park the counter at its maximum.
    assign fail_d = (fail_q >= FAIL_MAX) ? FAIL_MAX : fail_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOCKED;
            fail_q     <= '0;
            lck_q      <= '0;
            key_q      <= '0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
        end else if (prod_mode) begin
            state_q    <= ST_LOCKED;
            lck_q      <= '0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_LOCKED: begin
                    if (unlock_req) begin
                        key_q   <= key;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (key_q == fuse_key) begin
                        state_q    <= ST_UNLOCKED;
                        fail_q     <= '0;
                        unlocked_q <= 1'b1;
                    end else if (fail_d >= FAIL_MAX) begin
                        state_q   <= ST_LOCKOUT;
                        fail_q    <= fail_d;
                        lck_q     <= LCK_LOAD;
                        lockout_q <= 1'b1;
                    end else begin
                        state_q <= ST_LOCKED;
                        fail_q  <= fail_d;
                    end
                end
                ST_UNLOCKED: begin
                    if (relock) begin
                        state_q    <= ST_LOCKED;
                        unlocked_q <= 1'b0;
                    end
                end
                ST_LOCKOUT: begin
                    if (lck_q == '0) begin
                        state_q   <= ST_LOCKED;
                        fail_q    <= '0;
                        lockout_q <= 1'b0;
                    end else begin
                        lck_q <= lck_q - 1'b1;
                    end
                end
                default: state_q <= ST_LOCKED;
            endcase
        end
    end

    assign unlocked = unlocked_q;
    assign lockout  = lockout_q;

endmodule

// File: rtl/secure_debug_readout.sv
// Channel capture registers with a key-protected single-cycle debug read port.
module secure_debug_readout
    import dbg_sec_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 1024,
    localparam int CH_W       = calc_ch_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    input  logic                     prod_mode,
    input  logic [DATA_W-1:0]        fuse_key,
    input  logic                     dbg_unlock_req,
    input  logic [DATA_W-1:0]        dbg_key,
    input  logic                     dbg_relock,
    input  logic                     dbg_rd_req,
    input  logic [CH_W-1:0]          dbg_rd_ch,
    output logic                     dbg_rd_ack,
    output logic [DATA_W-1:0]        dbg_rd_data,
    output logic                     dbg_rd_err,
    output logic                     dbg_unlocked,
    output logic                     dbg_lockout
);

    logic [NUM_CH*DATA_W-1:0] data_out_q;
    logic                     ack_q;
    logic [DATA_W-1:0]        rd_data_q;
    logic                     err_q;
    logic                     rd_ok;
    logic [DATA_W-1:0]        rd_sel;

    dbg_auth_fsm #(
        .DATA_W      (DATA_W),
        .MAX_FAILS   (MAX_FAILS),
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) u_auth (
        .clk        (clk),
        .rst        (rst),
        .prod_mode  (prod_mode),
        .fuse_key   (fuse_key),
        .unlock_req (dbg_unlock_req),
        .key        (dbg_key),
        .relock     (dbg_relock),
        .unlocked   (dbg_unlocked),
        .lockout    (dbg_lockout)
    );

    // The state at the request cycle decides, so a same-cycle relock still reads.
    always_comb begin
        rd_sel = '0;
        rd_ok  = dbg_unlocked && (int'(dbg_rd_ch) < NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(dbg_rd_ch) == i) begin
                rd_sel = data_out_q[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
            ack_q      <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            data_out_q <= data_in;
            ack_q      <= dbg_rd_req;
            rd_data_q  <= (dbg_rd_req && rd_ok) ? rd_sel : '0;
            err_q      <= dbg_rd_req && !rd_ok;
        end
    end

    assign data_out    = data_out_q;
    assign dbg_rd_ack  = ack_q;
    assign dbg_rd_data = rd_data_q;
    assign dbg_rd_err  = err_q;

endmodule

// File: tb/tb_secure_debug_readout.sv
// Directed bench for secure_debug_readout; a second 5-channel instance covers
// out-of-range channel selects that a 2-bit select cannot express.
module tb_secure_debug_readout;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] data_in;
    logic [127:0] data_out;
    logic [159:0] data_in5;
    logic [159:0] data_out5;
    logic         prod_mode;
    logic [31:0]  fuse_key;
    logic         dbg_unlock_req;
    logic [31:0]  dbg_key;
    logic         dbg_relock;
    logic         dbg_rd_req;
    logic [2:0]   rd_ch5;
    logic [1:0]   dbg_rd_ch;
    logic         ack, err, unl, lck;
    logic [31:0]  rdata;
    logic         ack5, err5, unl5, lck5;
    logic [31:0]  rdata5;

    int n_chk = 0;
    int n_err = 0;
    int n;

    assign dbg_rd_ch = rd_ch5[1:0];

    always #5 clk = ~clk;

    secure_debug_readout u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out),
        .prod_mode(prod_mode), .fuse_key(fuse_key),
        .dbg_unlock_req(dbg_unlock_req), .dbg_key(dbg_key), .dbg_relock(dbg_relock),
        .dbg_rd_req(dbg_rd_req), .dbg_rd_ch(dbg_rd_ch), .dbg_rd_ack(ack),
        .dbg_rd_data(rdata), .dbg_rd_err(err), .dbg_unlocked(unl), .dbg_lockout(lck)
    );

    secure_debug_readout #(.NUM_CH(5)) u_dut5 (
        .clk(clk), .rst(rst), .data_in(data_in5), .data_out(data_out5),
        .prod_mode(prod_mode), .fuse_key(fuse_key),
        .dbg_unlock_req(dbg_unlock_req), .dbg_key(dbg_key), .dbg_relock(dbg_relock),
        .dbg_rd_req(dbg_rd_req), .dbg_rd_ch(rd_ch5), .dbg_rd_ack(ack5),
        .dbg_rd_data(rdata5), .dbg_rd_err(err5), .dbg_unlocked(unl5), .dbg_lockout(lck5)
    );

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic try_key(input logic [31:0] k);
        dbg_unlock_req = 1'b1;
        dbg_key        = k;
        step();
        dbg_unlock_req = 1'b0;
        dbg_key        = '0;
        step();
    endtask

    task automatic rd(input logic [2:0] ch);
        dbg_rd_req = 1'b1;
        rd_ch5     = ch;
        step();
        dbg_rd_req = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        prod_mode      = 1'b0;
        fuse_key       = 32'hA5A5A5A5;
        dbg_unlock_req = 1'b0;
        dbg_key        = '0;
        dbg_relock     = 1'b0;
        dbg_rd_req     = 1'b0;
        rd_ch5         = '0;
        data_in  = {32'hDEADBEEF, 32'h12345678, 32'h22222222, 32'h11111111};
        data_in5 = {32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        step();
        step();

        check("rst_data_out", data_out, '0);
        check("rst_ack", ack, 1'b0);
        check("rst_rdata", rdata, '0);
        check("rst_err", err, 1'b0);
        check("rst_unlocked", unl, 1'b0);
        check("rst_lockout", lck, 1'b0);

        rst = 1'b0;
        step();
        check("capture", data_out, data_in);

        rd(3'd0);
        check("locked_rd_ack", ack, 1'b1);
        check("locked_rd_data", rdata, '0);
        check("locked_rd_err", err, 1'b1);
        step();
        check("ack_one_cycle", ack, 1'b0);

        dbg_unlock_req = 1'b1;
        dbg_key        = 32'hA5A5A5A5;
        step();
        dbg_unlock_req = 1'b0;
        dbg_key        = '0;
        check("unlock_in_check", unl, 1'b0);
        step();
        check("unlock_ok", unl, 1'b1);

        rd(3'd7);
        check("ch7_ack", ack5, 1'b1);
        check("ch7_data", rdata5, '0);
        check("ch7_err", err5, 1'b1);
        rd(3'd4);
        check("ch4_data", rdata5, 32'h55555555);
        check("ch4_err", err5, 1'b0);

        rd(3'd2);
        check("ch2_ack", ack, 1'b1);
        check("ch2_data", rdata, 32'h12345678);
        check("ch2_err", err, 1'b0);

        rd(3'd3);
        check("b2b_ch3_data", rdata, 32'hDEADBEEF);
        dbg_rd_req      = 1'b1;
        rd_ch5          = 3'd1;
        data_in[63:32]  = 32'hCAFEF00D;
        step();
        dbg_rd_req = 1'b0;
        check("b2b_ch1_ack", ack, 1'b1);
        check("b2b_ch1_sampled", rdata, 32'h22222222);
        step();
        check("idle_ack", ack, 1'b0);
        check("idle_data", rdata, '0);
        check("capture_update", data_out[63:32], 32'hCAFEF00D);

        dbg_relock = 1'b1;
        dbg_rd_req = 1'b1;
        rd_ch5     = 3'd0;
        step();
        dbg_relock = 1'b0;
        dbg_rd_req = 1'b0;
        check("relock_rd_data", rdata, 32'h11111111);
        check("relock_rd_err", err, 1'b0);
        check("relock_state", unl, 1'b0);

        for (int i = 0; i < 3; i++) begin
            try_key(32'h00000001);
            check("wrong_key_lockout", lck, (i == 2));
            check("wrong_key_unlocked", unl, 1'b0);
        end

        n = 0;
        do begin
            dbg_unlock_req = (n == 10);
            dbg_key        = (n == 10) ? 32'hA5A5A5A5 : 32'h0;
            dbg_rd_req     = (n == 50);
            rd_ch5         = 3'd0;
            step();
            n++;
            if (n == 51) check("lockout_rd_err", err, 1'b1);
            if (n == 100) check("lockout_key_ignored", unl, 1'b0);
        end while (lck && n < 2000);
        dbg_unlock_req = 1'b0;
        dbg_rd_req     = 1'b0;
        check("lockout_cycles", n, 1024);
        try_key(32'hA5A5A5A5);
        check("unlock_after_lockout", unl, 1'b1);

        prod_mode = 1'b1;
        step();
        check("prod_forces_lock", unl, 1'b0);
        try_key(32'hA5A5A5A5);
        check("prod_key_ignored", unl, 1'b0);
        prod_mode = 1'b0;
        step();

        for (int i = 0; i < 3; i++) try_key(32'h00000002);
        check("lockout_again", lck, 1'b1);
        rst        = 1'b1;
        dbg_rd_req = 1'b1;
        step();
        dbg_rd_req = 1'b0;
        check("rst_lockout_flag", lck, 1'b0);
        check("rst_abort_ack", ack, 1'b0);
        check("rst_abort_data_out", data_out, '0);
        rst = 1'b0;
        step();
        check("no_ack_after_rst", ack, 1'b0);
        try_key(32'hA5A5A5A5);
        check("unlock_after_rst", unl, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
